// File: rtl/fpu_sched_pkg.sv
// Shared types for the fsqrt scheduler: requester ID, issue tag
// and the fsqrt pipeline latency used by the unit wrapper.
package fpu_sched_pkg;

  localparam int FSQRT_LAT = 3;
  localparam int MAX_NREQ  = 8;
  localparam int ID_W      = $clog2(MAX_NREQ);

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/fsqrt_resp_fifo.sv
// Per-requester response FIFO with registered head.
// Ports: clk, rst_n, push/wdata, pop, head, empty, full.
module fsqrt_resp_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] wdata,
  input  logic        pop,
  output logic [31:0] head,
  output logic        empty,
  output logic        full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] rptr_q, wptr_q, rnext;
  logic [CW-1:0] cnt_q;
  logic [31:0]   head_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // push into a full FIFO is only taken if a pop frees a slot
  assign do_push = push & (~full | do_pop);
  assign rnext   = inc(rptr_q);
  assign head    = head_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (do_push) wptr_q <= inc(wptr_q);
      if (do_pop)  rptr_q <= rnext;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      // head tracks the entry that will be oldest next cycle
      if (do_pop) begin
        if (cnt_q > CW'(1))
          head_q <= mem_q[rnext];
        else if (do_push)
          head_q <= wdata;
      end else if (empty && do_push) begin
        head_q <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/fsqrt_sched.sv
// Round-robin scheduler sharing one pipelined fsqrt among NREQ
// requesters; tag pipe steers results, credits bound FIFOs.
module fsqrt_sched
  import fpu_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int LAT   = FSQRT_LAT,
  parameter int DEPTH = 4
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_x,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [NREQ*32-1:0] resp_y,
  input  logic [NREQ-1:0]   resp_ready,
  output logic              fu_valid,
  output logic [31:0]       fu_x,
  input  logic [31:0]       fu_y,
  input  logic              fu_out_valid,
  output logic              err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] credit_q [NREQ];
  req_id_t       rr_last_q, issue_id_q, gnt_id;
  logic [NREQ-1:0] elig, grant, acc;
  logic [NREQ-1:0] push, pop, empty, full;
  logic          accept, found;
  int unsigned   idx;
  tag_t          tag_q [LAT];
  tag_t          tag_out;
  logic          fu_valid_q;
  logic [31:0]   fu_x_q;
  logic          err_q, err_d;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] & (credit_q[i] != '0);
  end

  // search starts one past the last grant and wraps
  always_comb begin
    grant  = '0;
    gnt_id = rr_last_q;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_last_q) + k) % NREQ;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = req_id_t'(idx);
      end
    end
  end

  assign req_ready = grant & {NREQ{rstn}};
  assign acc       = req_valid & req_ready;
  assign accept    = |acc;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      fu_valid_q <= 1'b0;
      fu_x_q     <= '0;
      issue_id_q <= '0;
      rr_last_q  <= req_id_t'(NREQ - 1);
    end else begin
      fu_valid_q <= accept;
      if (accept) begin
        fu_x_q     <= req_x[gnt_id*32 +: 32];
        issue_id_q <= gnt_id;
        rr_last_q  <= gnt_id;
      end
    end
  end

  assign fu_valid = fu_valid_q;
  assign fu_x     = fu_x_q;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++)
        tag_q[i] <= '0;
    end else begin
      tag_q[0].valid <= fu_valid_q;
      tag_q[0].id    <= issue_id_q;
      for (int i = 1; i < LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[LAT-1];

  always_comb begin
    push = '0;
    for (int i = 0; i < NREQ; i++)
      push[i] = fu_out_valid & tag_out.valid
              & (tag_out.id == req_id_t'(i));
  end

  assign pop = resp_valid & resp_ready;

  // tag/result misalignment or overflow latches until reset
  always_comb begin
    err_d = err_q;
    if (fu_out_valid != tag_out.valid)
      err_d = 1'b1;
    if (|(push & full & ~pop))
      err_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREQ; i++)
        credit_q[i] <= CW'(DEPTH);
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({acc[i], pop[i]})
          2'b10:   credit_q[i] <= credit_q[i] - CW'(1);
          2'b01:   credit_q[i] <= credit_q[i] + CW'(1);
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_fifo
    fsqrt_resp_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk  (sys_clk),
      .rst_n(rstn),
      .push (push[g]),
      .wdata(fu_y),
      .pop  (pop[g]),
      .head (resp_y[g*32 +: 32]),
      .empty(empty[g]),
      .full (full[g])
    );
    assign resp_valid[g] = ~empty[g];
  end

endmodule

// File: tb/tb_fsqrt_sched.sv
// Directed bench for fsqrt_sched with a stand-in fsqrt pipe
// and a per-requester scoreboard of expected results.
module tb_fsqrt_sched;

  localparam int NREQ  = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic sys_clk = 1'b0;
  logic rstn;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ-1:0]    resp_valid, resp_ready;
  logic [NREQ*32-1:0] req_x, resp_y;
  logic               fu_valid, fu_out_valid, err;
  logic [31:0]        fu_x, fu_y;
  logic               force_ov;

  logic [LAT-1:0] pv;
  logic [31:0]    pd [LAT];

  int n_cmp = 0;
  int n_bad = 0;
  int nacc;
  logic [NREQ-1:0] g;
  logic [31:0] sb [NREQ][$];

  fsqrt_sched #(
    .NREQ (NREQ),
    .LAT  (LAT),
    .DEPTH(DEPTH)
  ) dut (
    .sys_clk     (sys_clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_y      (resp_y),
    .resp_ready  (resp_ready),
    .fu_valid    (fu_valid),
    .fu_x        (fu_x),
    .fu_y        (fu_y),
    .fu_out_valid(fu_out_valid),
    .err         (err)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] fsq(input logic [31:0] x);
    case (x)
      32'h40800000: return 32'h40000000;
      32'h3F800000: return 32'h3F800000;
      32'h41800000: return 32'h40800000;
      32'h41100000: return 32'h40400000;
      default:
        if (x[31] && (x[30:0] != 31'd0)) return 32'h7FFFFFFF;
        else return x ^ 32'h5A5A5A5A;
    endcase
  endfunction

  // stand-in fsqrt unit, synchronous reset from rstn
  always @(posedge sys_clk) begin
    if (!rstn) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], fu_valid};
      pd[0] <= fsq(fu_x);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end

  assign fu_out_valid = pv[LAT-1] | force_ov;
  assign fu_y         = pd[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drv;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic smp;
    @(negedge sys_clk);
  endtask

  task automatic set_x(input int i, input logic [31:0] v);
    req_x[i*32 +: 32] = v;
  endtask

  function automatic logic [31:0] ry(input int i);
    return resp_y[i*32 +: 32];
  endfunction

  function automatic int sb_total();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += sb[i].size();
    return s;
  endfunction

  task automatic do_reset;
    drv;
    rstn      = 1'b0;
    req_valid = '0;
    repeat (5) drv;
    rstn = 1'b1;
  endtask

  // scoreboard: push on accept, pop and compare on response handshake
  always @(negedge sys_clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREQ; i++) sb[i].delete();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          n_cmp++;
          assert (sb[i].size() != 0) else begin
            n_bad++;
            $error("FAIL resp_extra%0d: observed %08h expected none",
                   i, ry(i));
          end
          if (sb[i].size() != 0)
            chk($sformatf("resp_y%0d", i), ry(i), sb[i].pop_front());
        end
        if (req_valid[i] && req_ready[i])
          sb[i].push_back(fsq(req_x[i*32 +: 32]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; req_valid = '0; req_x = '0;
    resp_ready = '1; force_ov = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1 rstn = 1'b1;
    smp;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_fu_valid", 32'(fu_valid), 32'd0);
    chk("rst_fu_x", fu_x, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_resp_y", 32'(|resp_y), 32'd0);

    // single op on requester 0
    drv; set_x(0, 32'h40800000); req_valid[0] = 1'b1;
    smp; chk("t1_grant", 32'(req_ready), 32'h1);
    for (int c = 1; c <= 5; c++) begin
      drv;
      if (c == 1) req_valid[0] = 1'b0;
      smp;
      if (c == 1) begin
        chk("t1_fu_valid", 32'(fu_valid), 32'd1);
        chk("t1_fu_x", fu_x, 32'h40800000);
      end
      if (c == 2) chk("t1_fu_pulse", 32'(fu_valid), 32'd0);
      if (c < 5) chk("t1_no_resp", 32'(resp_valid), 32'd0);
      else begin
        chk("t1_resp_valid", 32'(resp_valid), 32'h1);
        chk("t1_resp_y", ry(0), 32'h40000000);
      end
    end

    // all requesters continuously valid
    do_reset;
    set_x(0, 32'h40800000); set_x(1, 32'h3F800000);
    set_x(2, 32'h41800000); set_x(3, 32'h41100000);
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      smp; chk("t2_grant", 32'(req_ready), 32'(1 << (k % 4)));
      drv; set_x(k % 4, 32'h42000000 + 32'(k));
    end
    req_valid = '0;
    repeat (8) drv;
    smp;
    chk("t2_sb_drained", 32'(sb_total()), 32'd0);
    chk("t2_resp_idle", 32'(resp_valid), 32'd0);

    // negative operand on requester 1
    drv; set_x(1, 32'hBF800000); req_valid[1] = 1'b1;
    smp; chk("t3_grant", 32'(req_ready), 32'h2);
    for (int c = 1; c <= 5; c++) begin
      drv;
      if (c == 1) req_valid[1] = 1'b0;
      smp;
      if (c < 5) chk("t3_no_resp", 32'(resp_valid), 32'd0);
      else begin
        chk("t3_resp_valid", 32'(resp_valid), 32'h2);
        chk("t3_resp_y", ry(1), 32'h7FFFFFFF);
      end
    end
    chk("t3_err", 32'(err), 32'd0);

    // credit exhaustion on requester 2
    resp_ready[2] = 1'b0;
    drv; set_x(2, 32'h40800000); req_valid[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      smp;
      if (c < 4) chk("t4_grant", 32'(req_ready), 32'h4);
      else       chk("t4_blocked", 32'(req_ready), 32'd0);
      drv;
      if (c < 4) set_x(2, 32'h40800001 + 32'(c));
    end
    set_x(3, 32'h41100000); req_valid[3] = 1'b1;
    smp; chk("t4_other", 32'(req_ready), 32'h8);
    drv; req_valid[3] = 1'b0;
    repeat (3) drv;
    smp;
    chk("t4_full_valid", 32'(resp_valid[2]), 32'd1);
    chk("t4_still_blocked", 32'(req_ready), 32'd0);
    drv; resp_ready[2] = 1'b1;
    smp;
    chk("t4_pop_head", ry(2), 32'h40000000);
    chk("t4_pop_cycle", 32'(req_ready), 32'd0);
    drv; resp_ready[2] = 1'b0;
    smp; chk("t4_regrant", 32'(req_ready), 32'h4);
    drv; set_x(2, 32'h41800000);
    smp; chk("t4_reblocked", 32'(req_ready), 32'd0);
    drv; resp_ready[2] = 1'b1; req_valid[2] = 1'b0;
    repeat (10) drv;
    smp;
    chk("t4_sb_drained", 32'(sb_total()), 32'd0);
    chk("t4_err", 32'(err), 32'd0);

    // orphan result with empty tag pipe
    drv; force_ov = 1'b1;
    smp; chk("t5_err_pre", 32'(err), 32'd0);
    drv; force_ov = 1'b0;
    smp;
    chk("t5_err_set", 32'(err), 32'd1);
    chk("t5_no_push", 32'(resp_valid), 32'd0);
    repeat (3) drv;
    smp; chk("t5_err_sticky", 32'(err), 32'd1);

    // reset with operations in flight
    drv;
    set_x(0, 32'h40800000); set_x(1, 32'h3F800000);
    set_x(3, 32'h41800000);
    req_valid = 4'b1011;
    nacc = 0;
    for (int c = 0; c < 3; c++) begin
      smp; g = req_ready & req_valid;
      if (g != '0) nacc++;
      drv; req_valid = req_valid & ~g;
    end
    chk("t6_issued", 32'(nacc), 32'd3);
    rstn = 1'b0;
    smp;
    chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("t6_rst_fu_valid", 32'(fu_valid), 32'd0);
    chk("t6_rst_fu_x", fu_x, 32'd0);
    chk("t6_rst_err", 32'(err), 32'd0);
    chk("t6_rst_resp_y", 32'(|resp_y), 32'd0);
    repeat (5) drv;
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      smp; chk("t6_no_resp", 32'(resp_valid), 32'd0);
      drv;
    end
    smp; chk("t6_err", 32'(err), 32'd0);

    // credits back at DEPTH after reset
    resp_ready[0] = 1'b0;
    drv; set_x(0, 32'h40800000); req_valid[0] = 1'b1;
    nacc = 0;
    for (int c = 0; c < 7; c++) begin
      smp;
      if (req_ready[0]) nacc++;
      drv;
      if (req_ready[0]) set_x(0, 32'h43000000 + 32'(c));
    end
    chk("t6_credits", 32'(nacc), 32'(DEPTH));
    req_valid = '0; resp_ready = '1;
    repeat (10) drv;
    smp;
    chk("t6_sb_drained", 32'(sb_total()), 32'd0);
    chk("t6_err_end", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
